// File: rtl/matriz_mult_seq_pkg.sv
// Shared definitions for the sequential matrix multiplier: FSM encoding,
// default geometry and the packed-element offset helper.
package matriz_mult_seq_pkg;

    localparam int DEF_N     = 5;
    localparam int DEF_W     = 8;
    localparam int DEF_BUS_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FINISH  = 2'd2
    } state_e;

    // Bit offset of element (r,c) in a row-major packed N x N matrix of W-bit words.
    function automatic int unsigned elem_off(input int unsigned r, input int unsigned c,
                                             input int unsigned n, input int unsigned w);
        return w * (c + n * r);
    endfunction

endpackage

// File: rtl/matriz_mult_seq_mac.sv
// Multiply-accumulate slice: keeps a 2W+3 bit running sum and presents the
// truncated or saturated element value plus an overflow flag for the final write.
module matriz_mac #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         last,
    input  logic         sat_en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         ovf
);

    localparam int ACC_W = 2 * W + 3;
    localparam logic [ACC_W-1:0] MAX_V = ACC_W'({W{1'b1}});

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [2*W-1:0]   prod;
    logic [ACC_W-1:0] sum;

    assign prod = a * b;
    assign sum  = acc_q + ACC_W'(prod);
    assign ovf  = (sum > MAX_V);
    assign res  = (sat_en && ovf) ? {W{1'b1}} : sum[W-1:0];

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = last ? '0 : sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

endmodule

// File: rtl/matriz_mult_seq.sv
// Sequential M x M matrix multiplier: one multiply-accumulate per cycle over
// latched operands, results written element by element into a registered bus.
module matriz_mult_seq
    import matriz_mult_seq_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int W     = DEF_W,
    parameter int BUS_W = DEF_BUS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       size,
    input  logic             sat_en,
    input  logic [BUS_W-1:0] matriz_a,
    input  logic [BUS_W-1:0] matriz_b,
    output logic [BUS_W-1:0] data_c,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    localparam int OFF_W = $clog2(BUS_W);

    state_e           state_q, state_d;
    logic [BUS_W-1:0] a_q, a_d, b_q, b_d, data_c_q, data_c_d;
    logic [3:0]       m_q, m_d, i_q, i_d, j_q, j_d, k_q, k_d;
    logic             sat_q, sat_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic             mac_clr, mac_en, mac_last, mac_ovf;
    logic [W-1:0]     mac_res;
    logic [OFF_W-1:0] off_a, off_b, off_c;
    logic [3:0]       m_eff;

    // Out-of-range sizes fall back to the full dimension.
    assign m_eff = (size == 4'd0 || size > 4'(N)) ? 4'(N) : size;

    assign off_a = OFF_W'(elem_off(32'(i_q), 32'(k_q), N, W));
    assign off_b = OFF_W'(elem_off(32'(k_q), 32'(j_q), N, W));
    assign off_c = OFF_W'(elem_off(32'(i_q), 32'(j_q), N, W));

    matriz_mac #(.W(W)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (mac_clr),
        .en     (mac_en),
        .last   (mac_last),
        .sat_en (sat_q),
        .a      (a_q[off_a +: W]),
        .b      (b_q[off_b +: W]),
        .res    (mac_res),
        .ovf    (mac_ovf)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        sat_d    = sat_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        data_c_d = data_c_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        mac_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = matriz_a;
                    b_d      = matriz_b;
                    m_d      = m_eff;
                    sat_d    = sat_en;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    data_c_d = '0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    mac_clr  = 1'b1;
                    state_d  = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                mac_en = 1'b1;
                if (k_q == m_q - 4'd1) begin
                    // Last term of C[i][j]: commit the element and advance j, then i.
                    mac_last              = 1'b1;
                    data_c_d[off_c +: W]  = mac_res;
                    if (mac_ovf) ovf_d    = 1'b1;
                    k_d = '0;
                    if (j_q == m_q - 4'd1) begin
                        j_d = '0;
                        if (i_q == m_q - 4'd1) begin
                            i_d     = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_FINISH;
                        end else begin
                            i_d = i_q + 4'd1;
                        end
                    end else begin
                        j_d = j_q + 4'd1;
                    end
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            sat_q    <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            data_c_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            sat_q    <= sat_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            data_c_q <= data_c_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign data_c    = data_c_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule
